// File: rtl/period_meter.sv
// Period and high-time meter for a slow external signal.
// Counts fast clk cycles between edges of the synchronized sig_in.
module period_meter #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_R,
    MEAS_H,
    MEAS_L,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic rise, fall, tc;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ht_tmp_q, ht_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic to_q, to_d;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign tc   = &cnt_q;

  always_comb begin
    state_d  = state_q;
    ht_tmp_d = ht_tmp_q;
    period_d = period_q;
    high_d   = high_q;
    busy_d   = busy_q;
    to_d     = to_q;
    done_d   = 1'b0;
    cnt_d    = tc ? cnt_q : cnt_q + ONE;
    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          state_d = WAIT_R;
          cnt_d   = '0;
          to_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      WAIT_R: begin
        if (rise) begin
          state_d = MEAS_H;
          cnt_d   = ONE;
        end else if (tc) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          to_d     = 1'b1;
          period_d = '0;
          high_d   = '0;
        end
      end
      MEAS_H: begin
        if (fall) begin
          state_d  = MEAS_L;
          ht_tmp_d = cnt_q;
        end else if (tc) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          to_d     = 1'b1;
          period_d = '0;
          high_d   = '0;
        end
      end
      MEAS_L: begin
        // an edge on the terminal-count cycle still counts
        if (rise) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          period_d = cnt_q;
          high_d   = ht_tmp_q;
        end else if (tc) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          to_d     = 1'b1;
          period_d = '0;
          high_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      ht_tmp_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      ht_tmp_q <= ht_tmp_d;
      period_q <= period_d;
      high_q   <= high_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      to_q     <= to_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = to_q;
  assign period    = period_q;
  assign high_time = high_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with an 8-bit counter.
// Vectors drive a square wave and compare results per measurement.
module tb_period_meter;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic         start;
  logic         sig_in;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [W-1:0] period;
  logic [W-1:0] high_time;

  int nchecks;
  int nerrors;

  period_meter #(.CNT_W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .sig_in    (sig_in),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .period    (period),
    .high_time (high_time)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string nm;
    int    hi;
    int    lo;
    int    ph;
    int    st;
    bit    extra;
    int    exp_nd;
    int    exp_p;
    int    exp_h;
    int    exp_to;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, output int nd, output int p,
                         output int h, output int to, output int bz_ok);
    int  per;
    int  dc;
    bit  dn;
    per   = (v.hi + v.lo > 0) ? v.hi + v.lo : 1;
    nd    = 0;
    p     = -1;
    h     = -1;
    to    = -1;
    bz_ok = 1;
    dc    = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      dn = done;
      if (dn) begin
        nd++;
        if (nd == 1) begin
          p  = int'(period);
          h  = int'(high_time);
          to = int'(timeout);
          dc = n;
        end
        if (busy) bz_ok = 0;
      end else if (n > v.st && dc < 0 && !busy) begin
        bz_ok = 0;
      end
      sig_in = ((n + v.ph) % per) < v.hi;
      start  = (n == v.st) ||
               (v.extra && (n == v.st + 5 || n == v.st + 20 || dn));
    end
    start = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int nd, p, h, to, bz;
    run_vec(v, nd, p, h, to, bz);
    chk({v.nm, "_ndone"}, nd, v.exp_nd);
    chk({v.nm, "_period"}, p, v.exp_p);
    chk({v.nm, "_high"}, h, v.exp_h);
    chk({v.nm, "_timeout"}, to, v.exp_to);
    chk({v.nm, "_busy"}, bz, 1);
  endtask

  vec_t vecs[10];
  vec_t v12;
  int   lat;
  int   bz;

  initial begin
    nchecks = 0;
    nerrors = 0;
    clr     = 1'b0;
    start   = 1'b0;
    sig_in  = 1'b0;

    vecs[0] = '{"sq_low",   10,  30, 10, 2, 1'b0, 1, 40, 10, 0};
    vecs[1] = '{"sq_mid",   10,  30,  0, 3, 1'b0, 1, 40, 10, 0};
    vecs[2] = '{"sq_extra", 10,  30, 10, 2, 1'b1, 1, 40, 10, 0};
    vecs[3] = '{"tmo_low",   0,   1,  0, 2, 1'b0, 1,  0,  0, 1};
    vecs[4] = '{"toggle_a",  1,   1,  0, 2, 1'b0, 1,  2,  1, 0};
    vecs[5] = '{"toggle_b",  1,   1,  0, 2, 1'b0, 1,  2,  1, 0};
    vecs[6] = '{"w7_5",      7,   5,  7, 2, 1'b0, 1, 12,  7, 0};
    vecs[7] = '{"p255",      5, 250,  5, 2, 1'b0, 1, 255, 5, 0};
    vecs[8] = '{"p256",      5, 251,  5, 2, 1'b0, 1,  0,  0, 1};
    vecs[9] = '{"sq_after",  10, 30, 10, 2, 1'b0, 1, 40, 10, 0};

    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) apply(vecs[i]);

    // terminal-count timing: 256 edges from acceptance to done
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bz    = 1;
    while (!done && lat < 400) begin
      if (!busy) bz = 0;
      @(negedge clk);
      lat++;
    end
    chk("tmo_latency", lat, 257);
    chk("tmo_busy_before", bz, 1);
    chk("tmo_busy_at_done", int'(busy), 0);
    chk("tmo_flag", int'(timeout), 1);
    chk("tmo_period", int'(period), 0);
    @(negedge clk);
    chk("tmo_done_pulse", int'(done), 0);
    chk("tmo_flag_held", int'(timeout), 1);

    apply(vecs[0]);

    // asynchronous clear in the middle of the low phase
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (10) @(negedge clk);
    sig_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("clr_pre_busy", int'(busy), 1);
    chk("clr_pre_period", int'(period), 40);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_busy", int'(busy), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_timeout", int'(timeout), 0);
    chk("clr_period", int'(period), 0);
    chk("clr_high", int'(high_time), 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    v12 = '{"post_clr", 7, 5, 7, 2, 1'b0, 1, 12, 7, 0};
    apply(v12);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow external periodic signal (e.g. a divided clock, a sensor tick, or a test-header pin), counted in fast system-clock cycles.
- This is the inverse of the team's clock dividers: they derive a slow clock from the fast one; this block measures a slow signal against the fast one.
- Results and a done/timeout status are presented to the control/display logic through a start/done handshake.

Parameters:
- CNT_W, 26, width of the cycle counter and of the result outputs. Maximum measurable period is 2**CNT_W-1 cycles (~1.34 s at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- clr  input  1  asynchronous active-low reset. Low resets all state; high is normal operation.
- start  input  1  single-cycle request to begin a measurement. Honoured only in IDLE.
- sig_in  input  1  asynchronous signal under measurement.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse when the results are updated.
- timeout  output  1  set with done when the measurement failed. Held until the next accepted start.
- period  output  CNT_W  rise-to-rise cycle count. Held until the next done.
- high_time  output  CNT_W  rise-to-fall cycle count. Held until the next done.

Behaviour:
- Reset: clr low asynchronously forces the following, regardless of current state:
  - state = IDLE;
  - busy, done and timeout = 0;
  - period, high_time and the counter = 0;
  - synchronizer flops = 0.
- Input path: sig_in passes through a 2-FF synchronizer (s1, s2) and then a history flop s3.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - Latency from sig_in to the edge strobe is fixed, so the measured counts are exact multiples of clk regardless of that latency.
- Counter cnt, CNT_W bits:
  - cleared to 0 when start is accepted;
  - loaded with 1 on the first rise;
  - otherwise increments every cycle while busy;
  - never wraps, because terminal count is the timeout condition.
- FSM states and transitions:
  - IDLE: busy=0. start=1 goes to WAIT_R and clears cnt and timeout. Period and high_time keep their old values.
  - WAIT_R: waits for the first rise and ignores fall, so a start issued while sig_in is already high never yields a partial pulse. rise loads cnt=1 and goes to MEAS_H.
  - MEAS_H: on fall, high_time_tmp <= cnt and go to MEAS_L.
  - MEAS_L: on rise, period <= cnt, high_time <= high_time_tmp, and go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Timeout: in WAIT_R, MEAS_H or MEAS_L, if cnt == 2**CNT_W-1 and the expected edge is not present in that cycle:
  - go to DONE with timeout=1;
  - period and high_time become 0.
  - An expected edge in the terminal-count cycle wins over the timeout.
- Result semantics:
  - period = clk cycles between the two rise strobes;
  - high_time = clk cycles between the rise and fall strobes.
  - Minimum resolvable high and low phases are 1 cycle each, giving period=2 and high_time=1.
- Simultaneous events:
  - start while busy or in DONE is ignored, with no restart.
  - rise and fall cannot both be true in the same cycle.
- All outputs are registered. done is registered together with the results in the same edge.

Test Plan:
- Square wave with 10 cycles high and 30 low, start with sig_in low -> one done, period=40, high_time=10, timeout=0, busy=1 throughout the measurement.
- Start issued 3 cycles into a high phase of the same wave -> the partial pulse is ignored; period=40, high_time=10.
- CNT_W=8, sig_in held low, start -> done with timeout=1, period=0, high_time=0 after cnt reaches 255 (256 cycles after acceptance); busy drops in the same cycle.
- Extra start pulses during busy and in the DONE cycle -> exactly one done per accepted start; results unaffected.
- clr pulled low mid-MEAS_L -> busy, done, timeout, period and high_time are 0 immediately, without a clk edge. After release, the next start measures a 7-high/5-low wave as period=12, high_time=7.
- sig_in toggling every clk cycle, synchronous to clk -> period=2, high_time=1; back-to-back starts give identical results.
